// File: rtl/pm_loader_if.sv
// Byte-source / program-memory bundle for pm_loader.
// The loader sits on the slave side; the byte source and the memory observer sit on the master side.
interface pm_loader_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 5
);
  logic              I_START;
  logic              I_BYTE_VALID;
  logic [BYTE_W-1:0] I_BYTE;
  logic              O_BYTE_READY;
  logic              O_PM_WE;
  logic [ADDR_W-1:0] O_PM_ADDR;
  logic [DATA_W-1:0] O_PM_WDATA;
  logic              O_CPU_HOLD;
  logic              O_DONE;
  logic              O_OVERFLOW;
  logic [ADDR_W:0]   O_WORD_COUNT;

  modport master (
    output I_START, I_BYTE_VALID, I_BYTE,
    input  O_BYTE_READY, O_PM_WE, O_PM_ADDR, O_PM_WDATA,
           O_CPU_HOLD, O_DONE, O_OVERFLOW, O_WORD_COUNT
  );

  modport slave (
    input  I_START, I_BYTE_VALID, I_BYTE,
    output O_BYTE_READY, O_PM_WE, O_PM_ADDR, O_PM_WDATA,
           O_CPU_HOLD, O_DONE, O_OVERFLOW, O_WORD_COUNT
  );
endinterface

// File: rtl/pm_loader.sv
// Program-memory loader: packs a byte stream into words, writes them at incrementing
// addresses and holds the CPU in reset until a halt word or a full memory ends the load.
module pm_loader #(
  parameter int                 DATA_W     = 32,
  parameter int                 BYTE_W     = 8,
  parameter int                 DEPTH      = 32,
  parameter int                 ADDR_W     = 5,
  parameter bit                 BIG_ENDIAN = 1'b1,
  parameter logic [DATA_W-1:0]  HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic       CLK,
  input logic       RESET,
  pm_loader_if.slave bus
);

  localparam int BYTES  = DATA_W / BYTE_W;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [BCNT_W-1:0]   byte_cnt_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   asm_q;
  logic [DATA_W-1:0]   asm_d;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   pm_addr_q;
  logic                ready_q;
  logic                we_q;
  logic                hold_q;
  logic                done_q;
  logic                ovf_q;

  logic                byte_fire;
  logic                last_byte;
  logic                last_addr;
  logic                halt_hit;

  // Shifting (rather than indexing by byte count) keeps the packer valid even when DATA_W == BYTE_W.
  always_comb begin
    asm_d = asm_q;
    if (BIG_ENDIAN) begin
      asm_d = (asm_q << BYTE_W) | DATA_W'(bus.I_BYTE);
    end else begin
      asm_d = (asm_q >> BYTE_W) | (DATA_W'(bus.I_BYTE) << (DATA_W - BYTE_W));
    end
  end

  assign byte_fire = bus.I_BYTE_VALID & ready_q;
  assign last_byte = (byte_cnt_q == BCNT_W'(BYTES - 1));
  assign last_addr = (count_q == CNT_W'(DEPTH - 1));
  assign halt_hit  = (wdata_q == HALT_WORD);

  // NOTE: every register here, including the assembly buffer, is cleared by the synchronous
  // reset and updated with non-blocking assignments so all state advances on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      wdata_q    <= '0;
      pm_addr_q  <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (bus.I_START) begin
      // A restart during WRITE only drops the strobe after the cycle it was already high.
      state_q    <= S_LOAD;
      byte_cnt_q <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hold_q <= 1'b1;
        end

        S_LOAD: begin
          if (byte_fire) begin
            asm_q <= asm_d;
            if (last_byte) begin
              state_q    <= S_WRITE;
              byte_cnt_q <= '0;
              ready_q    <= 1'b0;
              we_q       <= 1'b1;
              wdata_q    <= asm_d;
              pm_addr_q  <= count_q[ADDR_W-1:0];
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end

        S_WRITE: begin
          we_q       <= 1'b0;
          count_q    <= count_q + 1'b1;
          byte_cnt_q <= '0;
          if (halt_hit) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
          end else if (last_addr) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            ovf_q   <= 1'b1;
          end else begin
            state_q <= S_LOAD;
            ready_q <= 1'b1;
          end
        end

        S_DONE: begin
          ready_q <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          we_q    <= 1'b0;
          hold_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.O_BYTE_READY = ready_q;
  assign bus.O_PM_WE      = we_q;
  assign bus.O_PM_ADDR    = pm_addr_q;
  assign bus.O_PM_WDATA   = wdata_q;
  assign bus.O_CPU_HOLD   = hold_q;
  assign bus.O_DONE       = done_q;
  assign bus.O_OVERFLOW   = ovf_q;
  assign bus.O_WORD_COUNT = count_q;

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: a big-endian instance carries most scenarios,
// a little-endian instance checks byte order.
module tb_pm_loader;

  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic CLK;
  logic RESET;

  pm_loader_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();
  pm_loader_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus_le ();

  pm_loader #(
    .DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .BIG_ENDIAN(1'b1), .HALT_WORD(32'hFFFF_FFFF)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  pm_loader #(
    .DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .BIG_ENDIAN(1'b0), .HALT_WORD(32'hFFFF_FFFF)
  ) u_dut_le (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_le.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];

  // Record every program-memory write of the big-endian instance.
  always @(posedge CLK) begin
    if (bus.O_PM_WE === 1'b1) begin
      log_addr.push_back(bus.O_PM_ADDR);
      log_data.push_back(bus.O_PM_WDATA);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    bus.I_START = 1'b1;
    tick();
    bus.I_START = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.I_BYTE_VALID = 1'b1;
    bus.I_BYTE       = b;
    while (!bus.O_BYTE_READY && n < 50) begin
      tick();
      n++;
    end
    if (!bus.O_BYTE_READY) check("byte_ready_timeout", 64'(bus.O_BYTE_READY), 64'd1);
    tick();
    bus.I_BYTE_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, 64'(bus.O_BYTE_READY), 64'd0);
    check({pfx, "_we"},    64'(bus.O_PM_WE),      64'd0);
    check({pfx, "_addr"},  64'(bus.O_PM_ADDR),    64'd0);
    check({pfx, "_wdata"}, 64'(bus.O_PM_WDATA),   64'd0);
    check({pfx, "_hold"},  64'(bus.O_CPU_HOLD),   64'd1);
    check({pfx, "_done"},  64'(bus.O_DONE),       64'd0);
    check({pfx, "_ovf"},   64'(bus.O_OVERFLOW),   64'd0);
    check({pfx, "_count"}, 64'(bus.O_WORD_COUNT), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   idx;
    int   gaps;
    int   cyc;

    RESET               = 1'b0;
    bus.I_START         = 1'b0;
    bus.I_BYTE_VALID    = 1'b0;
    bus.I_BYTE          = '0;
    bus_le.I_START      = 1'b0;
    bus_le.I_BYTE_VALID = 1'b0;
    bus_le.I_BYTE       = '0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    RESET = 1'b1;
    tick();
    check("idle_hold", 64'(bus.O_CPU_HOLD), 64'd1);
    check("idle_ready", 64'(bus.O_BYTE_READY), 64'd0);

    // Little-endian packing: 01 02 03 04 -> 04030201 at address 0
    bus_le.I_START = 1'b1;
    tick();
    bus_le.I_START = 1'b0;
    check("le_ready", 64'(bus_le.O_BYTE_READY), 64'd1);
    bus_le.I_BYTE_VALID = 1'b1;
    bus_le.I_BYTE = 8'h01; tick();
    bus_le.I_BYTE = 8'h02; tick();
    bus_le.I_BYTE = 8'h03; tick();
    bus_le.I_BYTE = 8'h04; tick();
    bus_le.I_BYTE_VALID = 1'b0;
    check("le_we",    64'(bus_le.O_PM_WE),    64'd1);
    check("le_addr",  64'(bus_le.O_PM_ADDR),  64'd0);
    check("le_wdata", 64'(bus_le.O_PM_WDATA), 64'h0403_0201);

    // Big-endian, two words, with the one-cycle WRITE latency
    clear_log();
    pulse_start();
    check("be_ready_after_start", 64'(bus.O_BYTE_READY), 64'd1);
    send_word(32'h0011_2233);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    check("lat_we_n1",    64'(bus.O_PM_WE),      64'd1);
    check("lat_ready_n1", 64'(bus.O_BYTE_READY), 64'd0);
    tick();
    check("lat_we_n2",    64'(bus.O_PM_WE),      64'd0);
    check("lat_ready_n2", 64'(bus.O_BYTE_READY), 64'd1);
    check("lat_wdata_hold", 64'(bus.O_PM_WDATA), 64'h4455_6677);
    check("be_nwrites",   64'(log_addr.size()),  64'd2);
    check("be_addr0",     64'(log_addr[0]),      64'd0);
    check("be_data0",     64'(log_data[0]),      64'h0011_2233);
    check("be_addr1",     64'(log_addr[1]),      64'd1);
    check("be_data1",     64'(log_data[1]),      64'h4455_6677);
    check("be_count",     64'(bus.O_WORD_COUNT), 64'd2);
    check("be_done",      64'(bus.O_DONE),       64'd0);
    check("be_hold",      64'(bus.O_CPU_HOLD),   64'd1);

    // Halt word terminates the load (restart issued from LOAD)
    clear_log();
    pulse_start();
    check("restart_count", 64'(bus.O_WORD_COUNT), 64'd0);
    send_word(32'hCAFE_0001);
    send_word(32'hCAFE_0002);
    send_word(32'hFFFF_FFFF);
    check("halt_we",   64'(bus.O_PM_WE),   64'd1);
    check("halt_done_early", 64'(bus.O_DONE), 64'd0);
    tick();
    check("halt_done",  64'(bus.O_DONE),       64'd1);
    check("halt_hold",  64'(bus.O_CPU_HOLD),   64'd0);
    check("halt_ovf",   64'(bus.O_OVERFLOW),   64'd0);
    check("halt_count", 64'(bus.O_WORD_COUNT), 64'd3);
    bus.I_BYTE_VALID = 1'b1;
    bus.I_BYTE       = 8'h5A;
    for (int i = 0; i < 6; i++) tick();
    check("halt_ready_blocked", 64'(bus.O_BYTE_READY), 64'd0);
    bus.I_BYTE_VALID = 1'b0;
    check("halt_nwrites", 64'(log_addr.size()), 64'd3);
    check("halt_addr2",   64'(log_addr[2]),     64'd2);
    check("halt_data2",   64'(log_data[2]),     64'hFFFF_FFFF);
    check("halt_addr0",   64'(log_addr[0]),     64'd0);

    // Overflow: DEPTH non-halt words
    clear_log();
    pulse_start();
    check("reload_done", 64'(bus.O_DONE),     64'd0);
    check("reload_hold", 64'(bus.O_CPU_HOLD), 64'd1);
    for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + 32'(i));
    tick();
    bus.I_BYTE_VALID = 1'b1;
    bus.I_BYTE       = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    bus.I_BYTE_VALID = 1'b0;
    check("ovf_flag",     64'(bus.O_OVERFLOW),   64'd1);
    check("ovf_done",     64'(bus.O_DONE),       64'd1);
    check("ovf_hold",     64'(bus.O_CPU_HOLD),   64'd0);
    check("ovf_count",    64'(bus.O_WORD_COUNT), 64'd32);
    check("ovf_nwrites",  64'(log_addr.size()),  64'd32);
    check("ovf_last_addr", 64'(log_addr[31]),    64'd31);
    check("ovf_last_data", 64'(log_data[31]),    64'h1000_001F);
    pulse_start();
    check("ovf_cleared", 64'(bus.O_OVERFLOW), 64'd0);

    // Continuous valid: one ready gap per WRITE, no byte lost or repeated
    clear_log();
    idx  = 0;
    gaps = 0;
    cyc  = 0;
    bus.I_BYTE_VALID = 1'b1;
    bus.I_BYTE       = 8'h10;
    while (idx < 16 && cyc < 100) begin
      acc = bus.O_BYTE_READY;
      if (!acc) gaps++;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        bus.I_BYTE = 8'(8'h10 + idx);
      end
    end
    bus.I_BYTE_VALID = 1'b0;
    check("stream_bytes", 64'(idx), 64'd16);
    check("stream_gaps",  64'(gaps), 64'd3);
    tick();
    tick();
    check("stream_nwrites", 64'(log_addr.size()), 64'd4);
    check("stream_data0",   64'(log_data[0]),     64'h1011_1213);
    check("stream_data1",   64'(log_data[1]),     64'h1415_1617);
    check("stream_data2",   64'(log_data[2]),     64'h1819_1A1B);
    check("stream_data3",   64'(log_data[3]),     64'h1C1D_1E1F);
    check("stream_addr3",   64'(log_addr[3]),     64'd3);

    // Reset mid-word discards the partial bytes
    send_byte(8'hAA);
    send_byte(8'hBB);
    RESET = 1'b0;
    tick();
    check_reset_outputs("midrst");
    RESET = 1'b1;
    tick();
    clear_log();
    pulse_start();
    send_word(32'hDEAD_BEEF);
    tick();
    check("midrst_nwrites", 64'(log_addr.size()), 64'd1);
    check("midrst_addr0",   64'(log_addr[0]),     64'd0);
    check("midrst_data0",   64'(log_data[0]),     64'hDEAD_BEEF);
    check("midrst_count",   64'(bus.O_WORD_COUNT), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
